// File: rtl/exc_ctrl_pkg.sv
// exc_ctrl_pkg
//   Shared definitions for the MEM-stage exception/interrupt commit controller:
//   CP0 ExcCode constants, the controller state encoding, the badvaddr source
//   selector and the default exception entry vector.
package exc_ctrl_pkg;

  // CP0 Cause.ExcCode values
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  // Source of the faulting virtual address written to CP0 BadVAddr
  typedef enum logic [1:0] {
    BV_NONE = 2'd0,
    BV_PC   = 2'd1,
    BV_DATA = 2'd2
  } bv_sel_t;

endpackage

// File: rtl/exc_ctrl_prio_enc.sv
// exc_prio_enc
//   Combinational priority encoder: picks the highest-priority cause among a
//   pending interrupt and the per-instruction exception flags.
//   Ports:
//     int_pend              in   interrupt is pending and enabled
//     adel_if .. ades       in   exception flags
//     hit                   out  any exception/interrupt present
//     exc_code [4:0]        out  ExcCode of the winning cause
//     bv_sel   [1:0]        out  badvaddr source (bv_sel_t encoding)
module exc_prio_enc
  import exc_ctrl_pkg::*;
(
  input  logic       int_pend,
  input  logic       adel_if,
  input  logic       ri,
  input  logic       ov,
  input  logic       sys,
  input  logic       bp,
  input  logic       adel_ld,
  input  logic       ades,
  output logic       hit,
  output logic [4:0] exc_code,
  output logic [1:0] bv_sel
);

  always_comb begin
    hit      = 1'b1;
    exc_code = EXC_INT;
    bv_sel   = BV_NONE;
    if (int_pend) begin
      exc_code = EXC_INT;
    end else if (adel_if) begin
      exc_code = EXC_ADEL;
      bv_sel   = BV_PC;
    end else if (ri) begin
      exc_code = EXC_RI;
    end else if (ov) begin
      exc_code = EXC_OV;
    end else if (sys) begin
      exc_code = EXC_SYS;
    end else if (bp) begin
      exc_code = EXC_BP;
    end else if (adel_ld) begin
      exc_code = EXC_ADEL;
      bv_sel   = BV_DATA;
    end else if (ades) begin
      exc_code = EXC_ADES;
      bv_sel   = BV_DATA;
    end else begin
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl
//   MEM-stage exception/interrupt commit controller. On a triggering
//   instruction it emits a one-cycle CP0 entry (or ERET) pulse, flushes the
//   pipeline, waits for the data bus to drain and hands a PC redirect to IF
//   over a valid/ready handshake.
//   Optional build macro: INT_SYNC_EN -- 2-flop synchronizer on hardware_int.
//   Ports:
//     clk, rst (async, active-low)
//     valid_i, pc_i, is_bd_i, exception flags, eret_i, data_vaddr_i : MEM stage
//     hardware_int, is_ie, is_exl, int_mask, soft_int, errorpc       : CP0 state
//     mem_busy                                                       : data bus
//     is_exception, is_excep_return, is_bd, we_badvaddr, exc_code,
//     exc_pc, badvaddr                                               : to CP0
//     accept_o, flush_o                                              : pipeline
//     redirect_valid, redirect_ready, redirect_pc                    : to IF
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic        is_bd_i,
  input  logic        adel_if_i,
  input  logic        ri_i,
  input  logic        ov_i,
  input  logic        sys_i,
  input  logic        bp_i,
  input  logic        adel_ld_i,
  input  logic        ades_st_i,
  input  logic        eret_i,
  input  logic [31:0] data_vaddr_i,
  input  logic [5:0]  hardware_int,
  input  logic        is_ie,
  input  logic        is_exl,
  input  logic [7:0]  int_mask,
  input  logic [1:0]  soft_int,
  input  logic [31:0] errorpc,
  input  logic        mem_busy,
  output logic        is_exception,
  output logic        is_excep_return,
  output logic        is_bd,
  output logic        we_badvaddr,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_pc,
  output logic [31:0] badvaddr,
  output logic        accept_o,
  output logic        flush_o,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc
);

  logic [5:0] hw_int_s;

`ifdef INT_SYNC_EN
  logic [5:0] int_sync1_reg;
  logic [5:0] int_sync2_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_sync1_reg <= '0;
      int_sync2_reg <= '0;
    end else begin
      int_sync1_reg <= hardware_int;
      int_sync2_reg <= int_sync1_reg;
    end
  end

  assign hw_int_s = int_sync2_reg;
`else
  assign hw_int_s = hardware_int;
`endif

  logic       int_pend;
  logic       exc_hit;
  logic [4:0] exc_code_enc;
  logic [1:0] bv_sel;
  logic       trigger;
  logic [31:0] exc_pc_calc;
  logic [31:0] badvaddr_calc;

  assign int_pend = (|(int_mask & {hw_int_s, soft_int})) & is_ie & ~is_exl;

  exc_prio_enc u_prio (
    .int_pend (int_pend),
    .adel_if  (adel_if_i),
    .ri       (ri_i),
    .ov       (ov_i),
    .sys      (sys_i),
    .bp       (bp_i),
    .adel_ld  (adel_ld_i),
    .ades     (ades_st_i),
    .hit      (exc_hit),
    .exc_code (exc_code_enc),
    .bv_sel   (bv_sel)
  );

  state_t state_reg;
  state_t state_next;

  assign trigger = (state_reg == ST_IDLE) & valid_i & (int_pend | exc_hit | eret_i);

  // Modulo-2^32: a delay slot at PC 0 points EPC at 0xFFFF_FFFC
  assign exc_pc_calc = is_bd_i ? (pc_i - 32'd4) : pc_i;

  always_comb begin
    badvaddr_calc = 32'h0;
    case (bv_sel)
      BV_PC:   badvaddr_calc = pc_i;
      BV_DATA: badvaddr_calc = data_vaddr_i;
      default: badvaddr_calc = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    accept_o       = 1'b0;
    flush_o        = 1'b1;
    redirect_valid = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        accept_o = 1'b1;
        flush_o  = 1'b0;
        if (trigger) state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!mem_busy) state_next = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        if (redirect_ready) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // CP0 outputs are single-cycle pulses; everything clears when not triggering
  logic        is_exception_reg;
  logic        is_excep_return_reg;
  logic        is_bd_reg;
  logic        we_badvaddr_reg;
  logic [4:0]  exc_code_reg;
  logic [31:0] exc_pc_reg;
  logic [31:0] badvaddr_reg;
  logic        is_eret_reg;
  logic [31:0] redirect_pc_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_exception_reg    <= 1'b0;
      is_excep_return_reg <= 1'b0;
      is_bd_reg           <= 1'b0;
      we_badvaddr_reg     <= 1'b0;
      exc_code_reg        <= 5'h0;
      exc_pc_reg          <= 32'h0;
      badvaddr_reg        <= 32'h0;
      is_eret_reg         <= 1'b0;
      redirect_pc_reg     <= 32'h0;
    end else begin
      is_exception_reg    <= 1'b0;
      is_excep_return_reg <= 1'b0;
      is_bd_reg           <= 1'b0;
      we_badvaddr_reg     <= 1'b0;
      exc_code_reg        <= 5'h0;
      exc_pc_reg          <= 32'h0;
      badvaddr_reg        <= 32'h0;
      if (trigger) begin
        // Any exception or interrupt overrides an ERET on the same instruction
        is_exception_reg    <= exc_hit;
        is_excep_return_reg <= ~exc_hit;
        is_eret_reg         <= ~exc_hit;
        if (exc_hit) begin
          is_bd_reg       <= is_bd_i;
          we_badvaddr_reg <= (bv_sel != BV_NONE);
          exc_code_reg    <= exc_code_enc;
          exc_pc_reg      <= exc_pc_calc;
          badvaddr_reg    <= badvaddr_calc;
        end
      end
      // EPC is sampled on the way into REDIRECT, then held through the handshake
      if (state_reg == ST_DRAIN && !mem_busy) begin
        redirect_pc_reg <= is_eret_reg ? errorpc : EXC_VECTOR;
      end
    end
  end

  assign is_exception    = is_exception_reg;
  assign is_excep_return = is_excep_return_reg;
  assign is_bd           = is_bd_reg;
  assign we_badvaddr     = we_badvaddr_reg;
  assign exc_code        = exc_code_reg;
  assign exc_pc          = exc_pc_reg;
  assign badvaddr        = badvaddr_reg;
  assign redirect_pc     = redirect_pc_reg;

endmodule
